cacheline_adaptor: RTL

Bridges the cache datapath's 256-bit line interface and the 64-bit burst physical-memory port. Sits directly downstream of the cache data array and write-merge stage. Services two operations:
- **Line fill:** gathers four 64-bit memory beats into one 256-bit line for the cache.
- **Writeback:** streams an evicted dirty 256-bit line out to memory as four 64-bit beats.

---
 rtl/cacheline_adaptor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit, four-beat burst memory port.
// Optional CACHELINE_ADAPTOR_PERF_EN adds saturating fill/writeback completion counters.
`timescale 1ns/1ps
module cacheline_adaptor #(
    parameter int BEATS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    output logic         resp_o,
    input  logic [63:0]  burst_i,
    output logic [63:0]  burst_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    input  logic         resp_i
`ifdef CACHELINE_ADAPTOR_PERF_EN
    ,
    output logic [15:0]  rd_cnt_o,
    output logic [15:0]  wr_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, RBURST, WBURST, DONE} state_t;

    state_t       state, state_next;
    logic [1:0]   cnt;
    logic [255:0] wline;
    logic [26:0]  line_addr;
    logic         last_beat;
    logic         unused_addr_bits;

    assign unused_addr_bits = ^address_i[4:0];
    assign last_beat        = resp_i && (cnt == 2'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (write_i) begin
                    state_next = WBURST;
                end else if (read_i) begin
                    state_next = RBURST;
                end
            end
            RBURST:  if (last_beat) state_next = DONE;
            WBURST:  if (last_beat) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode the state register only, so they never follow read_i/write_i combinationally.
    assign read_o    = (state == RBURST);
    assign write_o   = (state == WBURST);
    assign resp_o    = (state == DONE);
    assign address_o = {line_addr, 5'd0};
    assign burst_o   = (state == WBURST) ? wline[{cnt, 6'd0} +: 64] : 64'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 2'd0;
            wline     <= 256'd0;
            line_addr <= 27'd0;
            line_o    <= 256'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_i) begin
                        wline     <= line_i;
                        line_addr <= address_i[31:5];
                    end else if (read_i) begin
                        line_addr <= address_i[31:5];
                    end
                end
                RBURST: begin
                    if (resp_i) begin
                        line_o[{cnt, 6'd0} +: 64] <= burst_i;
                        cnt                       <= cnt + 2'd1;
                    end
                end
                WBURST: begin
                    if (resp_i) begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: cnt <= 2'd0;
            endcase
        end
    end

`ifdef CACHELINE_ADAPTOR_PERF_EN
    logic op_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_write <= 1'b0;
            rd_cnt_o <= 16'd0;
            wr_cnt_o <= 16'd0;
        end else begin
            if (state == IDLE) begin
                op_write <= write_i;
            end
            if (state == DONE) begin
                if (op_write) begin
                    if (wr_cnt_o != 16'hFFFF) wr_cnt_o <= wr_cnt_o + 16'd1;
                end else begin
                    if (rd_cnt_o != 16'hFFFF) rd_cnt_o <= rd_cnt_o + 16'd1;
                end
            end
        end
    end
`endif

endmodule
